i2c_master: RTL and testbench

//   Single-transaction I2C bus master: after reset it issues START, sends a 7-bit

---
 rtl/i2c_master.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
//   Single-transaction I2C bus master. After reset it issues START, sends the
//   7-bit SLAVE_ADDR plus the R/W bit and checks the slave ACK. It then either
//   writes one byte (data_in) or reads one byte into data_out, and it finishes
//   with STOP. After that it parks in DONE with the bus released until the
//   next reset.
//
//   The open-drain pad logic is outside this block: sda_out=1 means release.
//   Each bit period is two clk cycles: a low phase (sclk=0), in which sda_out
//   may change, and a high phase (sclk=1). sda_in is sampled on the clk edge
//   that ends the high phase.
//
// Ports
//   clk       in   1  system clock; SCL runs at clk/2
//   rst       in   1  synchronous, active-low reset
//   rw        in   1  1 = read from slave, 0 = write data_in (latched at START)
//   data_in   in   8  byte to write (latched at START)
//   data_out  out  8  byte read from slave
//   state     out  3  FSM state: IDLE=0 ADDRESSING=1 WAITING=2 READING=3
//                     WRITING=4 DONE=5
//   sclk      out  1  I2C SCL
//   sda_in    in   1  I2C SDA as seen on the bus
//   sda_out   out  1  I2C SDA drive (1 = release/high)
// -----------------------------------------------------------------------------
module i2c_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] state,
  output logic       sclk,
  input  logic       sda_in,
  output logic       sda_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDRESSING = 3'd1,
    WAITING    = 3'd2,
    READING    = 3'd3,
    WRITING    = 3'd4,
    DONE       = 3'd5
  } state_t;

  // cnt_r counts clk cycles spent in the current state. Within a bit
  // period, cnt_r[0] selects the phase (0 = low, 1 = high), and cnt_r[3:1]
  // gives the bit index. Counts 16/17 are the trailing ACK/NACK bit period.
  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        rw_r, rw_s;
  logic [7:0]  data_r, data_s;
  logic [6:0]  shift_r, shift_s;
  logic [7:0]  data_out_r, data_out_s;
  logic        sclk_r, sda_r;
  logic [1:0]  bus_s;

  // Bus levels for a given (state, count) slot, returned as {sclk, sda}.
  // The registered pins are loaded from the slot being entered, so the pins
  // always match state_r/cnt_r and never glitch.
  function automatic logic [1:0] bus_drive(input state_t     st,
                                           input logic [4:0] cnt,
                                           input logic       rw_bit,
                                           input logic [7:0] wbyte);
    logic [7:0] addr_bits;
    logic [1:0] drv;
    addr_bits = {SLAVE_ADDR, rw_bit};
    case (st)
      IDLE: begin
        // Second IDLE cycle pulls SDA low with SCL high: START.
        if (cnt == 5'd2) drv = 2'b10;
        else             drv = 2'b11;
      end
      ADDRESSING: drv = {cnt[0], addr_bits[3'd7 - cnt[3:1]]};
      WAITING:    drv = {cnt[0], 1'b1};
      READING:    drv = {cnt[0], 1'b1};
      WRITING: begin
        if (cnt[4]) drv = {cnt[0], 1'b1};
        else        drv = {cnt[0], wbyte[3'd7 - cnt[3:1]]};
      end
      DONE: begin
        // STOP: SDA low under low SCL, raise SCL, then release SDA.
        if (cnt == 5'd0)      drv = 2'b00;
        else if (cnt == 5'd1) drv = 2'b10;
        else                  drv = 2'b11;
      end
      default: drv = 2'b11;
    endcase
    return drv;
  endfunction

  // Next-state, bit counter, latches and receive shift register.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + 5'd1;
    rw_s       = rw_r;
    data_s     = data_r;
    shift_s    = shift_r;
    data_out_s = data_out_r;
    case (state_r)
      IDLE: begin
        if (cnt_r == 5'd1) begin
          // Entering the START cycle: capture the transaction request.
          rw_s   = rw;
          data_s = data_in;
        end else if (cnt_r >= 5'd2) begin
          state_s = ADDRESSING;
          cnt_s   = 5'd0;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      ADDRESSING: begin
        if (cnt_r == 5'd15) begin
          state_s = WAITING;
          cnt_s   = 5'd0;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      WAITING: begin
        if (cnt_r[0]) begin
          cnt_s = 5'd0;
          if (!sda_in) state_s = rw_r ? READING : WRITING;
          else         state_s = DONE;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      READING: begin
        if (cnt_r[0] && !cnt_r[4]) shift_s = {shift_r[5:0], sda_in};
        else                       shift_s = shift_r;
        // The eighth high phase completes the byte.
        if (cnt_r == 5'd15) data_out_s = {shift_r, sda_in};
        else                data_out_s = data_out_r;
        if (cnt_r == 5'd17) begin
          state_s = DONE;
          cnt_s   = 5'd0;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      WRITING: begin
        // The slave's data ACK is deliberately not examined.
        if (cnt_r == 5'd17) begin
          state_s = DONE;
          cnt_s   = 5'd0;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      DONE: begin
        // Saturate once STOP is complete so the bus stays released.
        if (cnt_r >= 5'd2) cnt_s = 5'd2;
        else               cnt_s = cnt_r + 5'd1;
      end
      default: begin
        // Unreachable encodings: park with the bus released.
        state_s = DONE;
        cnt_s   = 5'd2;
      end
    endcase
  end

  // Pin levels for the slot that is about to be entered.
  always_comb begin
    bus_s = bus_drive(state_s, cnt_s, rw_s, data_s);
  end

  // State, datapath and registered bus pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 5'd0;
      rw_r       <= 1'b0;
      data_r     <= 8'h00;
      shift_r    <= 7'h00;
      data_out_r <= 8'h00;
      sclk_r     <= 1'b1;
      sda_r      <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rw_r       <= rw_s;
      data_r     <= data_s;
      shift_r    <= shift_s;
      data_out_r <= data_out_s;
      sclk_r     <= bus_s[1];
      sda_r      <= bus_s[0];
    end
  end

  assign state    = state_r;
  assign data_out = data_out_r;
  assign sclk     = sclk_r;
  assign sda_out  = sda_r;

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
//   Directed bench for i2c_master. For each transaction, the expected bus
//   trace {state, sclk, sda_out, data_out} for every clk period is built from
//   a time-based model of the transfer and queued. It is then popped and
//   compared at each falling clk edge, while the bench plays the slave on
//   sda_in.
// -----------------------------------------------------------------------------
module tb_i2c_master;

  localparam logic [6:0] ADDR = 7'h50;

  logic       clk;
  logic       rst;
  logic       rw;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [2:0] state;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;

  int n_checks;
  int n_pass;
  logic [12:0] exp_q[$];

  i2c_master dut (
    .clk      (clk),
    .rst      (rst),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .state    (state),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_out  (sda_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {state, sclk, sda, data_out} in period p (p=1 follows the first
  // rising edge after reset release).
  function automatic logic [12:0] model(input int p, input logic rw_v,
                                        input logic [7:0] d, input logic ack,
                                        input logic [7:0] rb);
    logic [2:0] st;
    logic       sc;
    logic       sd;
    logic [7:0] dout;
    logic [7:0] ab;
    int         k;
    ab   = {ADDR, rw_v};
    dout = 8'h00;
    if (p <= 2) begin
      st = 3'd0; sc = 1'b1; sd = (p != 2);
    end else if (p <= 18) begin
      k = p - 3; st = 3'd1; sc = (k % 2 == 1); sd = ab[7 - k / 2];
    end else if (p <= 20) begin
      st = 3'd2; sc = (p == 20); sd = 1'b1;
    end else if (!ack) begin
      k = p - 21; st = 3'd5; sc = (k != 0); sd = (k >= 2);
    end else if (p <= 38) begin
      k  = p - 21;
      st = rw_v ? 3'd3 : 3'd4;
      sc = (k % 2 == 1);
      if (rw_v || k >= 16) sd = 1'b1;
      else                 sd = d[7 - k / 2];
      if (rw_v && k >= 16) dout = rb;
    end else begin
      k = p - 39; st = 3'd5; sc = (k != 0); sd = (k >= 2);
      if (rw_v) dout = rb;
    end
    return {st, sc, sd, dout};
  endfunction

  // Slave behaviour on sda_in during period p.
  function automatic logic slave_bit(input int p, input logic rw_v,
                                     input logic ack, input logic [7:0] rb);
    if (p == 19 || p == 20)                       return !ack;
    if (ack && rw_v && p >= 21 && p <= 36)        return rb[7 - (p - 21) / 2];
    if (ack && !rw_v && (p == 37 || p == 38))     return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed state=%0d sclk=%b sda=%b data_out=%h, expected state=%0d sclk=%b sda=%b data_out=%h",
                tag, obs[12:10], obs[9], obs[8], obs[7:0], exp[12:10], exp[9], exp[8], exp[7:0]);
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b0;
    sda_in = 1'b1;
    exp_q.push_back({3'd0, 1'b1, 1'b1, 8'h00});
    repeat (2) @(negedge clk);
    check(tag, {state, sclk, sda_out, data_out}, exp_q.pop_front());
  endtask

  // Release reset and follow n periods of one transaction. Inputs rw/data_in
  // are inverted after START to show they are no longer looked at.
  task automatic run_txn(input string tag, input logic rw_v, input logic [7:0] d,
                         input logic ack, input logic [7:0] rb, input int n);
    rw      = rw_v;
    data_in = d;
    sda_in  = 1'b1;
    for (int p = 1; p <= n; p++) exp_q.push_back(model(p, rw_v, d, ack, rb));
    rst = 1'b1;
    for (int p = 1; p <= n; p++) begin
      @(negedge clk);
      sda_in = slave_bit(p, rw_v, ack, rb);
      if (p == 3) begin
        rw      = ~rw_v;
        data_in = ~d;
      end
      check($sformatf("%s_p%0d", tag, p), {state, sclk, sda_out, data_out}, exp_q.pop_front());
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    rw       = 1'b0;
    data_in  = 8'h00;
    sda_in   = 1'b1;

    do_reset("reset");
    run_txn("write_a6", 1'b0, 8'hA6, 1'b1, 8'h00, 44);

    do_reset("reset_rd");
    run_txn("read_f6", 1'b1, 8'h5A, 1'b1, 8'hF6, 44);

    do_reset("reset_rd2");
    run_txn("read_2d", 1'b1, 8'hFF, 1'b1, 8'h2D, 42);

    do_reset("reset_nack");
    run_txn("addr_nack", 1'b0, 8'h3C, 1'b0, 8'h00, 26);

    do_reset("reset_abort");
    run_txn("read_abort", 1'b1, 8'h00, 1'b1, 8'hF6, 27);
    rst = 1'b0;
    exp_q.push_back({3'd0, 1'b1, 1'b1, 8'h00});
    @(negedge clk);
    check("abort_state", {state, sclk, sda_out, data_out}, exp_q.pop_front());
    run_txn("write_after_abort", 1'b0, 8'h81, 1'b1, 8'h00, 43);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
